cpc_bus_master: RTL and testbench

- Z80-style bus initiator for the CPC expansion bus. It takes the bus from the CPU via BUSRQ_B/BUSACK_B, then runs single memory or I/O read/write cycles with Z80 T-state sequencing.
- It is the initiator counterpart to our bus-decoding responder boards, e.g. the RAM banking register at I/O 0x7Fxx and the banked SRAM.
- It sits in the expansion CPLD behind a simple valid/ready command interface. The CPLD pads handle tristating using the *_OE outputs.

---
 rtl/cpc_bus_master.sv | 105 ++++++++++
 tb/tb_cpc_bus_master.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/cpc_bus_master.sv
// cpc_bus_master: Z80-style CPC expansion bus initiator running single memory/I-O cycles after a BUSRQ/BUSACK handshake
module cpc_bus_master #(
  parameter int MAX_WAIT = 15,
  parameter int ACK_TIMEOUT = 255,
  parameter int IO_AUTO_WAIT = 1
) (
  input  logic        CLK,
  input  logic        RESET_B,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_io,
  input  logic        req_wr,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_err,
  output logic        BUSRQ_B,
  input  logic        BUSACK_B,
  input  logic        READY,
  output logic [15:0] A,
  output logic        A_OE,
  input  logic [7:0]  D_IN,
  output logic [7:0]  D_OUT,
  output logic        D_OE,
  output logic        MREQ_B,
  output logic        IOREQ_B,
  output logic        RD_B,
  output logic        WR_B
);
  localparam int AW = $clog2(ACK_TIMEOUT + 2);
  localparam int WW = $clog2(MAX_WAIT + 2);
  localparam int IW = $clog2(IO_AUTO_WAIT + 2);
  typedef enum logic [2:0] {IDLE, BREQ, T1, T2, TW, T3, RSP, REL} state_t;
  state_t state, state_n;
  logic out_en, io, wr, err, ack_to;
  logic [15:0] addr;
  logic [7:0] wdata;
  logic [AW-1:0] acnt;
  logic [WW-1:0] wcnt;
  logic [IW-1:0] aw;
  logic accept, ack_last, wait_abort, held, act;
  assign ack_last = acnt >= AW'(ACK_TIMEOUT - 1);
  assign wait_abort = !READY && wcnt >= WW'(MAX_WAIT);
  assign held = !ack_to && state inside {T1, T2, TW, T3, RSP, REL};
  assign act = state inside {T2, TW, T3};
  assign req_ready = out_en && (state == IDLE || (state == REL && !ack_to));
  assign accept = req_valid && req_ready;
  assign rsp_valid = state == RSP;
  assign rsp_err = rsp_valid && err;
  assign BUSRQ_B = !(state == BREQ || held);
  assign A_OE = held;
  assign A = addr;
  assign D_OUT = wdata;
  assign D_OE = wr && state inside {T1, T2, TW, T3};
  assign MREQ_B = !(act && !io);
  assign IOREQ_B = !(act && io);
  assign RD_B = !(act && !wr);
  assign WR_B = !(act && wr);
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = accept ? BREQ : IDLE;
      BREQ: state_n = !BUSACK_B ? T1 : ack_last ? RSP : BREQ;
      T1: state_n = T2;
      T2: state_n = io || !READY ? TW : T3;
      TW: state_n = wait_abort ? RSP : !READY || aw > IW'(1) ? TW : T3;
      T3: state_n = RSP;
      RSP: state_n = REL;
      default: state_n = accept ? T1 : IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (!RESET_B) begin
      state <= IDLE;
      {out_en, io, wr, err, ack_to} <= '0;
      addr <= '0;
      wdata <= '0;
      rsp_rdata <= '0;
      acnt <= '0;
      wcnt <= '0;
      aw <= '0;
    end else begin
      state <= state_n;
      out_en <= 1'b1;
      if (accept) begin
        io <= req_io;
        wr <= req_wr;
        addr <= req_addr;
        wdata <= req_wdata;
        err <= 1'b0;
        ack_to <= 1'b0;
      end
      if (state == BREQ && BUSACK_B && ack_last) begin
        err <= 1'b1;
        ack_to <= 1'b1;
      end
      if (state == TW && wait_abort) err <= 1'b1;
      if (state == T3 && !wr) rsp_rdata <= D_IN;
      acnt <= state == BREQ && !ack_last ? acnt + 1'b1 : '0;
      wcnt <= state == T2 ? WW'(!io && !READY) : state == TW && !READY && !wait_abort ? wcnt + 1'b1 : wcnt;
      aw <= state == T2 ? IW'(io ? IO_AUTO_WAIT : 0) : aw - IW'(aw != '0);
    end
  end
endmodule

// File: tb/tb_cpc_bus_master.sv
// tb_cpc_bus_master: directed self-checking bench for cpc_bus_master
module tb_cpc_bus_master;
  logic CLK = 0, RESET_B = 0, req_valid = 0, req_io = 0, req_wr = 0, BUSACK_B = 1, READY = 1;
  logic [15:0] req_addr = 0;
  logic [7:0] req_wdata = 0, D_IN = 0;
  logic req_ready, rsp_valid, rsp_err, BUSRQ_B, A_OE, D_OE, MREQ_B, IOREQ_B, RD_B, WR_B;
  logic [7:0] rsp_rdata, D_OUT;
  logic [15:0] A;
  logic [3:0] strb;
  int n_chk = 0, n_pass = 0;
  int idx, g_idx, r_idx, n_mr, n_io, n_rd, n_wr, n_doe, n_bad, n_dbad, n_rqhi;
  logic r_err, rq_acc;
  logic [7:0] r_data, cur_wd;
  logic [15:0] cur_a;
  logic [3:0] r_strb;
  cpc_bus_master dut (
    .CLK(CLK), .RESET_B(RESET_B), .req_valid(req_valid), .req_ready(req_ready),
    .req_io(req_io), .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .BUSRQ_B(BUSRQ_B), .BUSACK_B(BUSACK_B), .READY(READY), .A(A), .A_OE(A_OE),
    .D_IN(D_IN), .D_OUT(D_OUT), .D_OE(D_OE), .MREQ_B(MREQ_B), .IOREQ_B(IOREQ_B),
    .RD_B(RD_B), .WR_B(WR_B)
  );
  assign strb = {MREQ_B, IOREQ_B, RD_B, WR_B};
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic issue(input logic io, input logic wr, input logic [15:0] a, input logic [7:0] d);
    int k;
    req_valid = 1;
    req_io = io;
    req_wr = wr;
    req_addr = a;
    req_wdata = d;
    cur_a = a;
    cur_wd = d;
    k = 0;
    while (!req_ready && k < 10) begin
      @(negedge CLK);
      k++;
    end
    chk("accept", req_ready, 1);
    rq_acc = BUSRQ_B;
    @(negedge CLK);
    req_valid = 0;
  endtask
  task automatic run(input int gdly, input int rlow, input logic [7:0] din);
    int rq, act;
    rq = 0; act = 0; idx = 0; g_idx = -1; r_idx = -1;
    n_mr = 0; n_io = 0; n_rd = 0; n_wr = 0; n_doe = 0; n_bad = 0; n_dbad = 0; n_rqhi = 0;
    READY = 1;
    D_IN = din;
    while (r_idx < 0 && idx < 400) begin
      n_mr += int'(!MREQ_B);
      n_io += int'(!IOREQ_B);
      n_rd += int'(!RD_B);
      n_wr += int'(!WR_B);
      n_rqhi += int'(BUSRQ_B);
      if (D_OE) begin
        n_doe++;
        if (D_OUT != cur_wd) n_dbad++;
      end
      if (A_OE && A != cur_a) n_dbad++;
      if (strb != 4'hF && !A_OE) n_bad++;
      if (!MREQ_B && !IOREQ_B) n_bad++;
      if (!RD_B && !WR_B) n_bad++;
      if (rsp_valid) begin
        r_idx = idx;
        r_err = rsp_err;
        r_data = rsp_rdata;
        r_strb = strb;
      end
      if (!BUSRQ_B) rq++;
      if (BUSACK_B && gdly >= 0 && rq > gdly) begin
        BUSACK_B = 0;
        g_idx = idx;
      end
      if (!MREQ_B || !IOREQ_B) begin
        act++;
        READY = act > rlow;
      end
      if (r_idx < 0) begin
        @(negedge CLK);
        idx++;
      end
    end
    chk("rsp_seen", r_idx >= 0, 1);
  endtask
  task automatic post();
    @(negedge CLK);
    chk("rsp_one_cycle", rsp_valid, 0);
    @(negedge CLK);
    chk("released_busrq", BUSRQ_B, 1);
    chk("released_aoe", A_OE, 0);
    BUSACK_B = 1;
    READY = 1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) @(negedge CLK);
    chk("rst_strb", strb, 4'hF);
    chk("rst_busrq", BUSRQ_B, 1);
    chk("rst_oe", {A_OE, D_OE}, 0);
    chk("rst_a", A, 0);
    chk("rst_dout", D_OUT, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp", {rsp_valid, rsp_err}, 0);
    chk("rst_rdata", rsp_rdata, 0);
    RESET_B = 1;
    @(negedge CLK);
    chk("idle_req_ready", req_ready, 1);
    issue(1, 1, 16'h7F00, 8'hC5);
    run(2, 0, 8'h00);
    chk("iowr_ioreq", n_io, 3);
    chk("iowr_wr", n_wr, 3);
    chk("iowr_mreq_rd", n_mr + n_rd, 0);
    chk("iowr_doe", n_doe, 4);
    chk("iowr_latency", r_idx - g_idx, 5);
    chk("iowr_err", r_err, 0);
    chk("iowr_bus", n_bad + n_dbad, 0);
    post();
    issue(0, 0, 16'h4000, 8'h00);
    run(0, 0, 8'hA5);
    chk("mrd_mreq", n_mr, 2);
    chk("mrd_rd", n_rd, 2);
    chk("mrd_io_wr_doe", n_io + n_wr + n_doe, 0);
    chk("mrd_latency", r_idx - g_idx, 4);
    chk("mrd_rdata", r_data, 8'hA5);
    chk("mrd_err", r_err, 0);
    chk("mrd_bus", n_bad + n_dbad, 0);
    post();
    issue(0, 1, 16'h8001, 8'h3C);
    run(1, 3, 8'h77);
    chk("mwr_mreq", n_mr, 5);
    chk("mwr_wr", n_wr, 5);
    chk("mwr_doe", n_doe, 6);
    chk("mwr_latency", r_idx - g_idx, 7);
    chk("mwr_err", r_err, 0);
    chk("mwr_rdata_kept", r_data, 8'hA5);
    chk("mwr_bus", n_bad + n_dbad, 0);
    post();
    issue(0, 0, 16'h1234, 8'h00);
    run(0, 20, 8'h5A);
    chk("wto_mreq", n_mr, 16);
    chk("wto_rd", n_rd, 16);
    chk("wto_latency", r_idx - g_idx, 18);
    chk("wto_err", r_err, 1);
    chk("wto_strb_released", r_strb, 4'hF);
    chk("wto_rdata_kept", r_data, 8'hA5);
    post();
    issue(0, 1, 16'h0000, 8'h11);
    run(-1, 0, 8'h00);
    chk("ato_cycles", r_idx, 255);
    chk("ato_err", r_err, 1);
    chk("ato_no_strobe", n_mr + n_io + n_rd + n_wr + n_doe, 0);
    chk("ato_rdata_kept", r_data, 8'hA5);
    post();
    issue(1, 1, 16'h7F00, 8'hC4);
    run(1, 0, 8'h00);
    chk("b2b1_ioreq", n_io, 3);
    chk("b2b1_err", r_err, 0);
    D_IN = 8'h96;
    issue(0, 0, 16'h4000, 8'h00);
    chk("b2b_busrq_at_accept", rq_acc, 0);
    run(0, 0, 8'h96);
    chk("b2b2_latency", r_idx, 3);
    chk("b2b2_busrq_held", n_rqhi, 0);
    chk("b2b2_mreq", n_mr, 2);
    chk("b2b2_rdata", r_data, 8'h96);
    chk("b2b2_bus", n_bad + n_dbad, 0);
    post();
    issue(0, 0, 16'h2222, 8'h00);
    BUSACK_B = 0;
    for (int k = 0; k < 10 && MREQ_B; k++) @(negedge CLK);
    chk("rst_mid_t2", MREQ_B, 0);
    READY = 0;
    @(negedge CLK);
    chk("rst_mid_tw_held", strb, 4'b0101);
    RESET_B = 0;
    @(negedge CLK);
    chk("rst_mid_strb", strb, 4'hF);
    chk("rst_mid_busrq", BUSRQ_B, 1);
    chk("rst_mid_oe", {A_OE, D_OE}, 0);
    chk("rst_mid_rsp", rsp_valid, 0);
    RESET_B = 1;
    READY = 1;
    BUSACK_B = 1;
    @(negedge CLK);
    issue(0, 0, 16'h4000, 8'h00);
    run(0, 0, 8'h3A);
    chk("after_rst_latency", r_idx - g_idx, 4);
    chk("after_rst_rdata", r_data, 8'h3A);
    chk("after_rst_err", r_err, 0);
    post();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
